// File: rtl/mips32_mem_arbiter_pkg.sv
// mips32_mem_arbiter_pkg: shared encodings and memory sizing
// for the IF/MEM single-port memory arbiter.
package mips32_mem_arbiter_pkg;

    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_AW         = $clog2(DEF_DEPTH);
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    function automatic logic in_range(input logic [31:0] a, input int depth);
        return a < 32'(depth);
    endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: requester ports (IF, data), halt and
// RAM-side signals of the memory arbiter.
interface mips32_mem_arbiter_if
    import mips32_mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW
);
    logic          halt;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          err;
    logic          busy;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    modport slave (
        input  halt, if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output err, busy,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output halt, if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  err, busy,
        input  m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one synchronous single-port RAM between
// IF and MEM; data has priority, a starve counter forces IF through.
module mips32_mem_arbiter
    import mips32_mem_arbiter_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = DEF_AW,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk1,
    input  logic reset,
    mips32_mem_arbiter_if.slave bus
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e        r_state;
    state_e        w_next;
    owner_e        r_owner;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;
    logic [LW-1:0] r_lat;
    logic [SW-1:0] r_starve;

    logic w_take;
    logic w_win_if;
    logic w_oob;
    logic w_last;
    logic w_gnt;
    logic w_rvalid;
    logic w_en;

    assign w_oob    = !in_range(r_addr, DEPTH);
    assign w_last   = (r_lat == LW'(MEM_LAT - 1));
    assign w_win_if = bus.if_req &&
                      (!bus.d_req || r_starve == SW'(STARVE_MAX));

    // Next-state selection and per-state output decode
    always_comb begin
        w_next   = r_state;
        w_take   = 1'b0;
        w_gnt    = 1'b0;
        w_rvalid = 1'b0;
        w_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!bus.halt && (bus.if_req || bus.d_req)) begin
                    w_take = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                w_gnt  = 1'b1;
                w_en   = !w_oob;
                w_next = r_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (w_last) w_next = RESP;
            end
            RESP: begin
                w_rvalid = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.if_gnt    = w_gnt && (r_owner == OWN_IF);
    assign bus.d_gnt     = w_gnt && (r_owner == OWN_D);
    assign bus.if_rvalid = w_rvalid && (r_owner == OWN_IF);
    assign bus.d_rvalid  = w_rvalid && (r_owner == OWN_D);
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.err       = w_gnt && w_oob;
    assign bus.busy      = (r_state != IDLE);
    assign bus.m_en      = w_en;
    assign bus.m_we      = w_en && r_we;
    assign bus.m_addr    = w_en ? r_addr[AW-1:0] : '0;
    assign bus.m_wdata   = w_en ? r_wdata : '0;

    // State register
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Latch the winner's owner and operands when leaving IDLE
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            if (w_win_if) begin
                r_owner <= OWN_IF;
                r_we    <= 1'b0;
                r_addr  <= bus.if_addr;
                r_wdata <= '0;
            end else begin
                r_owner <= OWN_D;
                r_we    <= bus.d_we;
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_wdata;
            end
        end
    end

    // Count data grants that bypass a waiting IF request
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (!bus.if_req)
                r_starve <= '0;
            else if (w_take && w_win_if)
                r_starve <= '0;
            else if (w_take && r_starve != SW'(STARVE_MAX))
                r_starve <= r_starve + SW'(1);
        end
    end

    // Count RAM latency cycles spent in WAIT
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)
            r_lat <= '0;
        else if (r_state == ISSUE)
            r_lat <= '0;
        else if (r_state == WAIT && !w_last)
            r_lat <= r_lat + LW'(1);
    end

    // Capture read data for the owner on the last WAIT cycle
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (r_state == WAIT && w_last) begin
            if (r_owner == OWN_IF)
                r_if_rdata <= w_oob ? '0 : bus.m_rdata;
            else
                r_d_rdata  <= w_oob ? '0 : bus.m_rdata;
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed stimulus with a grant/response
// scoreboard checked by an independent negedge monitor.
module tb_mips32_mem_arbiter;

    typedef struct {
        bit          is_if;
        bit          we;
        bit          err;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          cyc;
    } gnt_t;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk1  = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    gnt_t gq[$];
    rsp_t rq[$];
    logic [31:0] ram [0:1023];

    mips32_mem_arbiter_if bus();

    mips32_mem_arbiter dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    // RAM model: one-cycle synchronous read, known words at reset
    always @(posedge clk1) begin
        if (reset) begin
            ram[5]   <= 32'h2800_000A;
            ram[476] <= 32'h1234_5678;
        end else if (bus.m_en) begin
            if (bus.m_we) ram[bus.m_addr] <= bus.m_wdata;
            else          bus.m_rdata     <= ram[bus.m_addr];
        end
    end

    // Monitor: pop and compare on every grant and every response
    gnt_t g;
    rsp_t r;
    always @(negedge clk1) begin
        if (bus.if_gnt || bus.d_gnt) begin
            n_cmp++;
            if (gq.size() == 0) begin
                n_bad++;
                $display("FAIL gnt_unexpected: if_gnt=%0b d_gnt=%0b cyc=%0d, required no grant",
                         bus.if_gnt, bus.d_gnt, cyc);
            end else begin
                g = gq.pop_front();
                if (bus.if_gnt !== g.is_if || bus.d_gnt !== !g.is_if ||
                    bus.err !== g.err || bus.m_en !== !g.err ||
                    bus.m_we !== (g.we && !g.err) ||
                    (!g.err && (bus.m_addr !== g.addr || bus.m_wdata !== g.wdata)) ||
                    (g.cyc >= 0 && cyc != g.cyc)) begin
                    n_bad++;
                    $display("FAIL gnt_check: if_gnt=%0b d_gnt=%0b err=%0b m_en=%0b m_we=%0b m_addr=%0d m_wdata=%h cyc=%0d, required is_if=%0b err=%0b we=%0b addr=%0d wdata=%h cyc=%0d",
                             bus.if_gnt, bus.d_gnt, bus.err, bus.m_en, bus.m_we,
                             bus.m_addr, bus.m_wdata, cyc,
                             g.is_if, g.err, g.we, g.addr, g.wdata, g.cyc);
                end
            end
        end
        if (bus.if_rvalid || bus.d_rvalid) begin
            n_cmp++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: if_rvalid=%0b d_rvalid=%0b cyc=%0d, required no response",
                         bus.if_rvalid, bus.d_rvalid, cyc);
            end else begin
                r = rq.pop_front();
                if (bus.if_rvalid !== r.is_if || bus.d_rvalid !== !r.is_if ||
                    (r.is_if ? bus.if_rdata : bus.d_rdata) !== r.data ||
                    (r.cyc >= 0 && cyc != r.cyc)) begin
                    n_bad++;
                    $display("FAIL rsp_check: if_rvalid=%0b d_rvalid=%0b if_rdata=%h d_rdata=%h cyc=%0d, required is_if=%0b data=%h cyc=%0d",
                             bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata,
                             cyc, r.is_if, r.data, r.cyc);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ctl"}, 32'({bus.if_gnt, bus.if_rvalid, bus.d_gnt,
            bus.d_rvalid, bus.err, bus.busy, bus.m_en, bus.m_we}), 32'd0);
        chk({nm, "_maddr"}, 32'(bus.m_addr), 32'd0);
        chk({nm, "_mwdata"}, bus.m_wdata, 32'd0);
        chk({nm, "_ifrdata"}, bus.if_rdata, 32'd0);
        chk({nm, "_drdata"}, bus.d_rdata, 32'd0);
    endtask

    task automatic expect_gnt(input bit is_if, input bit we, input bit err,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int c);
        gnt_t e;
        e.is_if = is_if;
        e.we    = we;
        e.err   = err;
        e.addr  = a[9:0];
        e.wdata = wd;
        e.cyc   = c;
        gq.push_back(e);
    endtask

    task automatic expect_rsp(input bit is_if, input logic [31:0] d,
                              input int c);
        rsp_t e;
        e.is_if = is_if;
        e.data  = d;
        e.cyc   = c;
        rq.push_back(e);
    endtask

    task automatic wait_gnt(input bit is_if, input string nm);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(is_if ? bus.if_gnt : bus.d_gnt) && k < 50);
        if (k >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no grant within 50 cycles, required grant", nm);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.busy && k < 50);
        if (k >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy stuck for 50 cycles, required idle", nm);
        end
    endtask

    // One transaction from IDLE: expected timing is N+1 / N+3
    task automatic xact(input bit is_if, input bit we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit err, input logic [31:0] rd);
        expect_gnt(is_if, we, err, a, wd, cyc + 1);
        if (!we) expect_rsp(is_if, rd, cyc + 3);
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = a;
            bus.d_wdata = wd;
        end
        wait_gnt(is_if, "xact_gnt");
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        wait_idle("xact_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ord;
        bit         f;
        int         c0;
        int         ng;
        int         k;

        bus.halt    = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        tick(2);
        chk_idle("reset");
        reset = 1'b0;
        tick();

        // IF read of Mem[5]
        xact(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 32'h2800_000A);
        chk("t1_if_rdata", bus.if_rdata, 32'h2800_000A);

        // Store then load at 20
        xact(1'b0, 1'b1, 32'd20, 32'hDEAD_BEEF, 1'b0, 32'd0);
        xact(1'b0, 1'b0, 32'd20, 32'd0, 1'b0, 32'hDEAD_BEEF);
        chk("t2_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);

        // Both requesters held: D,D,D,IF,D,D,D,IF
        ord = 8'b1000_1000;
        c0  = cyc;
        for (int i = 0; i < 8; i++) begin
            f = ord[i];
            expect_gnt(f, 1'b0, 1'b0, f ? 32'd5 : 32'd20, 32'd0,
                       c0 + 1 + 4 * i);
            expect_rsp(f, f ? 32'h2800_000A : 32'hDEAD_BEEF,
                       c0 + 3 + 4 * i);
        end
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd5;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'd20;
        bus.d_wdata = 32'd0;
        ng = 0;
        k  = 0;
        while (ng < 8 && k < 100) begin
            tick();
            k++;
            if (bus.if_gnt || bus.d_gnt) ng++;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        chk("t3_grant_count", 32'(ng), 32'd8);
        wait_idle("t3_idle");

        // Out-of-range load, dropped store, untouched alias word
        xact(1'b0, 1'b0, 32'd1024, 32'd0, 1'b1, 32'd0);
        chk("t4_oob_rdata", bus.d_rdata, 32'd0);
        xact(1'b0, 1'b1, 32'd1500, 32'hBAD0_BAD0, 1'b1, 32'd0);
        xact(1'b0, 1'b0, 32'd476, 32'd0, 1'b0, 32'h1234_5678);

        // Halt blocks new grants
        bus.halt    = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_halt_busy", 32'(bus.busy), 32'd0);
            chk("t5_halt_gnt", 32'(bus.if_gnt), 32'd0);
        end
        expect_gnt(1'b1, 1'b0, 1'b0, 32'd5, 32'd0, cyc + 1);
        expect_rsp(1'b1, 32'h2800_000A, cyc + 3);
        bus.halt = 1'b0;
        wait_gnt(1'b1, "t5_gnt");
        bus.if_req = 1'b0;
        tick();
        bus.halt = 1'b1;
        chk("t5_wait_busy", 32'(bus.busy), 32'd1);
        wait_idle("t5_idle");
        bus.halt = 1'b0;
        chk("t5_if_rdata", bus.if_rdata, 32'h2800_000A);

        // Reset during WAIT aborts the read
        expect_gnt(1'b0, 1'b0, 1'b0, 32'd20, 32'd0, cyc + 1);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'd20;
        bus.d_wdata = 32'd0;
        wait_gnt(1'b0, "t6_gnt");
        bus.d_req = 1'b0;
        tick();
        chk("t6_in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_idle("t6_reset");
        tick(2);
        reset = 1'b0;
        tick(3);
        xact(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 32'h2800_000A);

        tick(2);
        n_cmp++;
        if (gq.size() != 0 || rq.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d grants / %0d responses left, required 0 / 0",
                     gq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
